// File: rtl/logical_pipe.sv
// logical_pipe: two-stage valid/ready pipeline computing a bitwise logic op
// on two N-bit operands, with zero/parity flags and a saturating count of
// completed output transfers.
module logical_pipe #(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N-1:0]     R,
   output logic             zero,
   output logic             parity,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
   localparam logic [OP_W-1:0] OP_NAND = 3'b100;
   localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
   localparam logic [OP_W-1:0] OP_ANDN = 3'b110;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // stage 1: captured operands
   logic [N-1:0]    a1;
   logic [N-1:0]    b1;
   logic [OP_W-1:0] op1;
   logic            v1;

   // stage 2 valid flag; R/zero/parity are the stage 2 payload
   logic            v2;

   logic [N-1:0]    res_c;
   logic            s2_load_c;
   logic            in_xfer_c;
   logic            out_xfer_c;

   // handshake decode; a full pipe can still accept when the head drains
   always_comb begin
      in_ready   = !v1 || !v2 || out_ready;
      s2_load_c  = v1 && (!v2 || out_ready);
      in_xfer_c  = in_valid && in_ready;
      out_xfer_c = v2 && out_ready;
   end

   assign out_valid = v2;

   // logic unit operating on the stage 1 operands
   always_comb begin
      res_c = '0;
      unique case (op1)
         OP_AND:  res_c = a1 & b1;
         OP_OR:   res_c = a1 | b1;
         OP_XOR:  res_c = a1 ^ b1;
         OP_NOR:  res_c = ~(a1 | b1);
         OP_NAND: res_c = ~(a1 & b1);
         OP_XNOR: res_c = ~(a1 ^ b1);
         OP_ANDN: res_c = a1 & ~b1;
         default: res_c = a1;
      endcase
   end

   // pipeline registers and completion counter
   always_ff @(posedge clk) begin
      if (reset) begin
         a1       <= '0;
         b1       <= '0;
         op1      <= '0;
         v1       <= 1'b0;
         v2       <= 1'b0;
         R        <= '0;
         zero     <= 1'b1;
         parity   <= 1'b0;
         done_cnt <= '0;
      end else begin
         if (in_xfer_c) begin
            a1  <= A;
            b1  <= B;
            op1 <= op;
            v1  <= 1'b1;
         end else if (s2_load_c) begin
            v1  <= 1'b0;
         end

         if (s2_load_c) begin
            R      <= res_c;
            zero   <= (res_c == '0);
            parity <= ^res_c;
            v2     <= 1'b1;
         end else if (out_xfer_c) begin
            v2     <= 1'b0;
         end

         if (out_xfer_c && (done_cnt != CNT_MAX)) begin
            done_cnt <= done_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_logical_pipe.sv
// Directed and randomised checks for logical_pipe.
module tb_logical_pipe;

   logic clk;
   int   vectors;
   int   miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance for directed vectors
   logic        r8, iv8, ir8, z8, p8, ov8, or8;
   logic [7:0]  a8, b8, q8;
   logic [2:0]  op8;
   logic [15:0] dc8;

   logical_pipe #(.N(8), .CNT_W(16)) u_d8 (
      .clk(clk), .reset(r8), .A(a8), .B(b8), .op(op8), .in_valid(iv8),
      .in_ready(ir8), .R(q8), .zero(z8), .parity(p8), .out_valid(ov8),
      .out_ready(or8), .done_cnt(dc8));

   // 8-bit instance with a 2-bit counter for saturation
   logic        rs, ivs, irs, zs, ps, ovs, ors;
   logic [7:0]  sa, sb, qs;
   logic [2:0]  ops;
   logic [1:0]  dcs;

   logical_pipe #(.N(8), .CNT_W(2)) u_sat (
      .clk(clk), .reset(rs), .A(sa), .B(sb), .op(ops), .in_valid(ivs),
      .in_ready(irs), .R(qs), .zero(zs), .parity(ps), .out_valid(ovs),
      .out_ready(ors), .done_cnt(dcs));

   // 32-bit instance for the random stall run
   logic        r32, iv32, ir32, z32, p32, ov32, or32;
   logic [31:0] a32, b32, q32;
   logic [2:0]  op32;
   logic [15:0] dc32;

   logical_pipe #(.N(32), .CNT_W(16)) u_d32 (
      .clk(clk), .reset(r32), .A(a32), .B(b32), .op(op32), .in_valid(iv32),
      .in_ready(ir32), .R(q32), .zero(z32), .parity(p32), .out_valid(ov32),
      .out_ready(or32), .done_cnt(dc32));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] o);
      case (o)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a | b);
         3'd4:    return ~(a & b);
         3'd5:    return ~(a ^ b);
         3'd6:    return a & ~b;
         default: return a;
      endcase
   endfunction

   logic [7:0]  sweep_exp [8];
   logic [31:0] sb_q [$];
   logic [31:0] e;
   int          xfers;

   initial begin
      vectors = 0;
      miscompares = 0;
      xfers = 0;
      sweep_exp = '{8'h81, 8'hE7, 8'h66, 8'h18, 8'h7E, 8'h99, 8'h42, 8'hC3};

      r8 = 1; iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0;
      rs = 1; ivs = 0; ors = 1; sa = 0; sb = 0; ops = 0;
      r32 = 1; iv32 = 0; or32 = 1; a32 = 0; b32 = 0; op32 = 0;
      step(); step();

      // reset state
      chk("rst_out_valid", 64'(ov8), 64'd0);
      chk("rst_R", 64'(q8), 64'h00);
      chk("rst_zero", 64'(z8), 64'd1);
      chk("rst_parity", 64'(p8), 64'd0);
      chk("rst_done_cnt", 64'(dc8), 64'd0);
      r8 = 0; rs = 0; r32 = 0;
      #1;
      chk("rst_in_ready", 64'(ir8), 64'd1);

      // op sweep: C3 op A5 for all eight ops, two-cycle latency
      for (int c = 0; c < 10; c++) begin
         if (c < 8) begin
            iv8 = 1; a8 = 8'hC3; b8 = 8'hA5; op8 = 3'(c);
         end else begin
            iv8 = 0;
         end
         step();
         if (c == 0) chk("sweep_lat_ov", 64'(ov8), 64'd0);
         if (c >= 1 && c <= 8) begin
            chk($sformatf("sweep_ov_%0d", c - 1), 64'(ov8), 64'd1);
            chk($sformatf("sweep_R_%0d", c - 1), 64'(q8), 64'(sweep_exp[c-1]));
            chk($sformatf("sweep_par_%0d", c - 1), 64'(p8), 64'(^sweep_exp[c-1]));
         end
      end
      chk("sweep_ov_idle", 64'(ov8), 64'd0);
      chk("sweep_done_cnt", 64'(dc8), 64'd8);

      // zero and parity flags
      iv8 = 1; a8 = 8'h0F; b8 = 8'hF0; op8 = 3'b000;
      step();
      a8 = 8'h01; b8 = 8'h00; op8 = 3'b001;
      step();
      chk("flag0_R", 64'(q8), 64'h00);
      chk("flag0_zero", 64'(z8), 64'd1);
      chk("flag0_parity", 64'(p8), 64'd0);
      iv8 = 0;
      step();
      chk("flag1_R", 64'(q8), 64'h01);
      chk("flag1_zero", 64'(z8), 64'd0);
      chk("flag1_parity", 64'(p8), 64'd1);
      step();
      chk("flag_done_cnt", 64'(dc8), 64'd10);

      // back-pressure: 2 accepted then stall, results held
      or8 = 0; iv8 = 1; op8 = 3'b111; b8 = 8'h00; a8 = 8'h11;
      step();
      chk("bp_ready_1", 64'(ir8), 64'd1);
      chk("bp_ov_1", 64'(ov8), 64'd0);
      a8 = 8'h22;
      step();
      chk("bp_ready_2", 64'(ir8), 64'd0);
      chk("bp_R_head", 64'(q8), 64'h11);
      a8 = 8'h33;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("bp_stall_ready_%0d", c), 64'(ir8), 64'd0);
         chk($sformatf("bp_stall_R_%0d", c), 64'(q8), 64'h11);
         chk($sformatf("bp_stall_ov_%0d", c), 64'(ov8), 64'd1);
      end
      or8 = 1;
      step();
      iv8 = 0;
      chk("bp_rel_R2", 64'(q8), 64'h22);
      chk("bp_rel_cnt1", 64'(dc8), 64'd11);
      step();
      chk("bp_rel_R3", 64'(q8), 64'h33);
      chk("bp_rel_ov3", 64'(ov8), 64'd1);
      step();
      chk("bp_drained_ov", 64'(ov8), 64'd0);
      chk("bp_done_cnt", 64'(dc8), 64'd13);

      // mid-operation reset with both stages full
      or8 = 0; iv8 = 1; op8 = 3'b111; a8 = 8'h55;
      step();
      a8 = 8'h66;
      step();
      chk("mr_full_ready", 64'(ir8), 64'd0);
      r8 = 1;
      step();
      chk("mr_ov", 64'(ov8), 64'd0);
      chk("mr_done_cnt", 64'(dc8), 64'd0);
      chk("mr_R", 64'(q8), 64'h00);
      chk("mr_zero", 64'(z8), 64'd1);
      r8 = 0; iv8 = 0; or8 = 1;
      #1;
      chk("mr_ready", 64'(ir8), 64'd1);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("mr_no_stale_%0d", c), 64'(ov8), 64'd0);
      end
      chk("mr_cnt_after", 64'(dc8), 64'd0);

      // counter saturation with CNT_W=2
      for (int k = 0; k < 7; k++) begin
         if (k < 5) begin
            ivs = 1; sa = 8'(k + 1); sb = 8'h00; ops = 3'b111;
         end else begin
            ivs = 0;
         end
         step();
         if (k >= 2) chk($sformatf("sat_cnt_%0d", k - 1), 64'(dcs), 64'((k - 1 > 3) ? 3 : k - 1));
      end

      // randomised stall against a scoreboard
      chk("rnd_ready", 64'(ir32), 64'd1);
      for (int c = 0; c < 10004; c++) begin
         if (c < 10000) begin
            iv32 = 1'($urandom);
            or32 = 1'($urandom);
            a32  = $urandom;
            b32  = $urandom;
            op32 = 3'($urandom);
         end else begin
            iv32 = 0;
            or32 = 1;
         end
         #1;
         if (iv32 && ir32) sb_q.push_back(ref_op(a32, b32, op32));
         if (ov32 && or32) begin
            if (sb_q.size() == 0) begin
               chk("rnd_spurious", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("rnd_R", 64'(q32), 64'(e));
               chk("rnd_zero", 64'(z32), 64'(e == 32'd0));
               chk("rnd_parity", 64'(p32), 64'(^e));
               xfers++;
            end
         end
         step();
      end
      chk("rnd_queue_empty", 64'(sb_q.size()), 64'd0);
      chk("rnd_done_cnt", 64'(dc32), 64'(xfers));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
